// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive/transmit types and default parameters
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;
  localparam int UART_CLKS_PER_BIT_DEF = 16;
  localparam int UART_DATA_BITS_DEF    = 8;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line plus host-side valid/ready byte bus of the receiver
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS_DEF
);
  logic                 Rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;
  modport slave (input Rx, rx_ready, output rx_data, rx_valid, frame_err, overrun, busy);
  modport master (output Rx, rx_ready, input rx_data, rx_valid, frame_err, overrun, busy);
endinterface

// File: rtl/uart_bit_sync.sv
// uart_bit_sync: two-flop synchronizer for the Rx line plus falling-edge detect
module uart_bit_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx_i,
  output logic rx_s_o,
  output logic fall_o
);
  logic [2:0] sh_q;
  // shift chain: [0] first sync flop, [1] synchronized line, [2] previous sample
  always_ff @(posedge clk) begin
    if (reset) sh_q <= '1;
    else sh_q <= {sh_q[1:0], rx_i};
  end
  assign rx_s_o = sh_q[1];
  assign fall_o = ~sh_q[1] & sh_q[2];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with one-entry valid/ready holding register
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = UART_DATA_BITS_DEF
) (
  input logic      clk,
  input logic      reset,
  uart_rx_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
  uart_rx_state_t       state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                 rx_s, fall, stop_done, rd, load;
  uart_bit_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .rx_i   (bus.Rx),
    .rx_s_o (rx_s),
    .fall_o (fall)
  );
  // frame sequencing: start-bit qualification, mid-bit data sampling, stop check
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    stop_done = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: if (cnt_q == HALF) begin
        cnt_d     = '0;
        bit_idx_d = '0;
        state_d   = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == FULL) begin
        cnt_d     = '0;
        shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
        bit_idx_d = bit_idx_q + 1'b1;
        if (bit_idx_q == LAST) state_d = STOP;
      end
      STOP: if (cnt_q == FULL) begin
        cnt_d     = '0;
        stop_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // holding register: a read in the same cycle frees the slot for a new byte
  always_comb begin
    rd          = rx_valid_q & bus.rx_ready;
    load        = stop_done & rx_s & (~rx_valid_q | rd);
    rx_valid_d  = load | (rx_valid_q & ~rd);
    rx_data_d   = load ? shreg_q : rx_data_q;
    frame_err_d = stop_done & ~rx_s;
    overrun_d   = stop_done & rx_s & rx_valid_q & ~rd;
  end
  // state, counters and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scoreboard bench for the UART receiver
module tb_uart_rx;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int lat;
  int ferr0, ovr0;
  logic [7:0] exp_q[$];
  logic hold = 1'b0;
  logic [7:0] held = '0;
  uart_rx_if #(.DATA_BITS(8)) bus ();
  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive_bit(input logic v);
    bus.Rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask
  task automatic idle(input int n);
    bus.Rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (reset) hold = 1'b0;
    else begin
      if (bus.rx_valid && bus.rx_ready) begin
        check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
      end
      if (hold && bus.rx_valid) check("rx_data_stable", 32'(bus.rx_data), 32'(held));
      hold = bus.rx_valid && !bus.rx_ready;
      held = bus.rx_data;
      if (bus.frame_err) n_ferr++;
      if (bus.overrun) n_ovr++;
      if (bus.frame_err || bus.overrun) check("flags_exclusive", 32'(bus.frame_err & bus.overrun), 32'd0);
    end
  end
  initial begin
    bus.Rx = 1'b1;
    bus.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_data", 32'(bus.rx_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_flags", 32'({bus.frame_err, bus.overrun}), 32'd0);
    idle(8);
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        lat = 0;
        do begin
          @(posedge clk);
          #1;
          lat++;
        end while (!bus.rx_valid && lat < 300);
        check("a5_latency", 32'(lat), 32'd155);
        check("a5_data", 32'(bus.rx_data), 32'hA5);
        @(posedge clk);
        #1;
        check("a5_valid_one_cycle", 32'(bus.rx_valid), 32'd0);
      end
    join
    idle(8);
    check("a5_no_flags", 32'(n_ferr + n_ovr), 32'd0);
    check("a5_sb_drained", 32'(exp_q.size()), 32'd0);
    bus.rx_ready = 1'b0;
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    check("ovr_pulse", 32'(n_ovr), 32'd1);
    check("ovr_valid_held", 32'(bus.rx_valid), 32'd1);
    check("ovr_data_kept", 32'(bus.rx_data), 32'h00);
    bus.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_read_clears", 32'(bus.rx_valid), 32'd0);
    check("ovr_sb_drained", 32'(exp_q.size()), 32'd0);
    idle(8);
    ferr0 = n_ferr;
    send_frame(8'h3C, 1'b0);
    idle(20);
    check("ferr_pulse", 32'(n_ferr - ferr0), 32'd1);
    check("ferr_no_valid", 32'(bus.rx_valid), 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle(8);
    check("after_ferr_sb_drained", 32'(exp_q.size()), 32'd0);
    ferr0 = n_ferr;
    ovr0 = n_ovr;
    bus.Rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("glitch_busy_high", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    bus.Rx = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("glitch_idle", 32'(bus.busy), 32'd0);
    check("glitch_no_valid", 32'(bus.rx_valid), 32'd0);
    check("glitch_no_flags", 32'((n_ferr - ferr0) + (n_ovr - ovr0)), 32'd0);
    check("glitch_data_kept", 32'(bus.rx_data), 32'h81);
    idle(8);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'((8'h5A >> i) & 8'h01));
    bus.Rx = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("mid_data_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_data", 32'(bus.rx_data), 32'd0);
    check("mid_rst_valid", 32'(bus.rx_valid), 32'd0);
    check("mid_rst_flags", 32'({bus.frame_err, bus.overrun}), 32'd0);
    reset = 1'b0;
    idle(32);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(8);
    check("after_rst_sb_drained", 32'(exp_q.size()), 32'd0);
    ferr0 = n_ferr;
    bus.Rx = 1'b0;
    repeat (3 * 10 * CPB) @(posedge clk);
    #1;
    check("break_idle", 32'(bus.busy), 32'd0);
    check("break_ferr_once", 32'(n_ferr - ferr0), 32'd1);
    check("break_no_valid", 32'(bus.rx_valid), 32'd0);
    idle(32);
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b1);
    idle(8);
    check("after_break_sb_drained", 32'(exp_q.size()), 32'd0);
    check("total_ferr", 32'(n_ferr), 32'd2);
    check("total_ovr", 32'(n_ovr), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
